bcd2bi_seq: RTL and testbench

Sequential BCD-to-binary converter: accepts a three-digit packed BCD value (000–999) and returns its 8-bit binary equivalent, with overflow and invalid-digit flags. It is the inverse of the processor's binary-to-BCD display path. It sits between BCD-format operand entry (switch/keypad digits) and the datapath's 8-bit registers. Conversion uses the reverse shift-and-subtract-3 algorithm, one iteration per clock, behind a start/done handshake.

---
 rtl/bcd2bi_seq_if.sv | 21 ++
 rtl/bcd2bi_seq.sv | 109 ++++++++++
 tb/tb_bcd2bi_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bcd2bi_seq_if.sv
// Handshake and data bundle for the sequential BCD-to-binary converter.
// The requester drives start/bcd_in; the converter returns status and result.
interface bcd2bi_seq_if;
   logic        start;
   logic [11:0] bcd_in;
   logic        busy;
   logic        done;
   logic [7:0]  dout;
   logic        ovf;
   logic        err;

   modport master (
      output start, bcd_in,
      input  busy, done, dout, ovf, err
   );

   modport slave (
      input  start, bcd_in,
      output busy, done, dout, ovf, err
   );
endinterface

// File: rtl/bcd2bi_seq.sv
// Sequential three-digit BCD to 8-bit binary converter.
// Reverse double-dabble: shift right once per clock, then subtract 3 from
// any BCD nibble that is 8 or more. Ten iterations move the whole value into
// the 10-bit binary accumulator; dout is its low byte, ovf flags > 255.
module bcd2bi_seq (
   input logic        clk,
   input logic        rst_n,
   bcd2bi_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t      state;
   logic [21:0] work;
   logic [21:0] shifted;
   logic [21:0] next_work;
   logic [3:0]  cnt;
   logic        digit_bad;
   logic        busy_r;
   logic        done_r;
   logic [7:0]  dout_r;
   logic        ovf_r;
   logic        err_r;

   // Detect any input digit above 9 (checked only when a request is accepted).
   always_comb begin
      digit_bad = (bus.bcd_in[11:8] > 4'd9) ||
                  (bus.bcd_in[7:4]  > 4'd9) ||
                  (bus.bcd_in[3:0]  > 4'd9);
   end

   // One iteration: zero-fill right shift, then per-nibble correction with no borrow across digits.
   always_comb begin
      shifted   = work >> 1;
      next_work = shifted;
      for (int unsigned i = 0; i < 3; i++) begin
         if (shifted[10 + 4*i + 3]) begin
            next_work[10 + 4*i +: 4] = shifted[10 + 4*i +: 4] - 4'd3;
         end
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         work   <= '0;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dout_r <= '0;
         ovf_r  <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               if (bus.start) begin
                  if (digit_bad) begin
                     err_r  <= 1'b1;
                     dout_r <= '0;
                     ovf_r  <= 1'b0;
                     done_r <= 1'b1;
                     state  <= DONE;
                  end else begin
                     work   <= {bus.bcd_in, 10'b0};
                     cnt    <= '0;
                     busy_r <= 1'b1;
                     state  <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work <= next_work;
               cnt  <= cnt + 4'd1;
               if (cnt == 4'd9) begin
                  dout_r <= next_work[7:0];
                  ovf_r  <= |next_work[9:8];
                  err_r  <= 1'b0;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.dout = dout_r;
   assign bus.ovf  = ovf_r;
   assign bus.err  = err_r;

endmodule

// File: tb/tb_bcd2bi_seq.sv
// Randomized self-checking bench for bcd2bi_seq against a decimal reference model.
module tb_bcd2bi_seq;

   logic clk;
   logic rst_n;
   int   compared   = 0;
   int   mismatched = 0;
   int   pulses     = 0;
   int   exp_pulses = 0;

   bcd2bi_seq_if bus ();

   bcd2bi_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every done pulse seen on the bus.
   always @(negedge clk) begin
      if (bus.done === 1'b1) pulses++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal value of three BCD digits, or invalid if any digit > 9.
   function automatic bit ref_bad(input logic [11:0] bcd);
      int unsigned h, t, o;
      h = (bcd / 256) % 16;
      t = (bcd / 16) % 16;
      o = bcd % 16;
      return (h > 9) || (t > 9) || (o > 9);
   endfunction

   function automatic int unsigned ref_value(input logic [11:0] bcd);
      return ((bcd / 256) % 16) * 100 + ((bcd / 16) % 16) * 10 + (bcd % 16);
   endfunction

   function automatic logic [11:0] to_bcd(input int unsigned v);
      logic [11:0] r;
      r[11:8] = 4'((v / 100) % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction

   // Issue one request from IDLE (called at a negedge) and check the outcome.
   // While the conversion runs, bcd_in is scrambled and start is either held
   // high (hold=1) or randomized; neither must affect the result.
   task automatic convert(input logic [11:0] bcd, input bit hold);
      int unsigned v;
      bit          bad;
      int          n;
      int          busy_cnt;
      bit          seen;
      v   = ref_value(bcd);
      bad = ref_bad(bcd);
      bus.start  = 1'b1;
      bus.bcd_in = bcd;
      @(posedge clk);
      exp_pulses++;
      n = 0;
      busy_cnt = 0;
      seen = 1'b0;
      while (n < 40) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy === 1'b1) busy_cnt++;
         bus.start  = hold ? 1'b1 : 1'($urandom);
         bus.bcd_in = 12'($urandom);
         @(posedge clk);
         n++;
      end
      if (!seen) begin
         chk("done_timeout", 32'(seen), 32'd1);
      end else begin
         chk("busy_with_done", 32'(bus.busy), 32'd0);
         chk("latency_edges", 32'(n), bad ? 32'd0 : 32'd10);
         chk("busy_cycles", 32'(busy_cnt), bad ? 32'd0 : 32'd10);
         chk("err", 32'(bus.err), 32'(bad));
         chk("ovf", 32'(bus.ovf), bad ? 32'd0 : 32'(v > 255));
         chk("dout", 32'(bus.dout), bad ? 32'd0 : 32'(v % 256));
      end
      bus.start = hold;
      @(posedge clk);
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
   endtask

   initial begin
      int unsigned order [1000];
      logic [11:0] r;
      int          d;

      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.bcd_in = 12'h000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_ovf",  32'(bus.ovf),  32'd0);
      chk("rst_err",  32'(bus.err),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases including the extreme values.
      convert(12'h255, 1'b0);
      convert(12'h999, 1'b0);
      convert(12'h000, 1'b0);
      convert(12'h128, 1'b0);
      convert(12'h1A3, 1'b0);
      convert(12'hF00, 1'b0);
      convert(12'h00A, 1'b0);

      // start held high with bcd_in changing every cycle; next request pinned to 123.
      convert(12'h042, 1'b1);
      convert(12'h123, 1'b0);

      // Abort a 0x300 conversion with a one-edge reset after iteration 5.
      bus.start  = 1'b1;
      bus.bcd_in = 12'h300;
      @(posedge clk);
      bus.start = 1'b0;
      repeat (5) begin
         @(negedge clk);
         bus.bcd_in = 12'($urandom);
         @(posedge clk);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_dout", 32'(bus.dout), 32'd0);
      chk("abort_ovf",  32'(bus.ovf),  32'd0);
      chk("abort_err",  32'(bus.err),  32'd0);
      d = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.done === 1'b1) d++;
      end
      chk("abort_no_done", 32'(d), 32'd0);
      convert(12'h300, 1'b0);

      // Random invalid-digit requests.
      repeat (20) begin
         do r = 12'($urandom); while (!ref_bad(r));
         convert(r, 1'b0);
      end

      // All 1000 valid inputs in a random order.
      for (int unsigned i = 0; i < 1000; i++) order[i] = i;
      for (int unsigned i = 999; i > 0; i--) begin
         int unsigned j;
         int unsigned tmp;
         j = $urandom_range(i, 0);
         tmp = order[i];
         order[i] = order[j];
         order[j] = tmp;
      end
      for (int unsigned i = 0; i < 1000; i++) begin
         convert(to_bcd(order[i]), 1'($urandom));
      end

      @(negedge clk);
      #1;
      chk("done_pulse_count", 32'(pulses), 32'(exp_pulses));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Safety net against a hung run.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
